// File: rtl/cordic_r_iter.sv
// Iterative rotation-mode CORDIC: rotates (x_in, y_in) by angle_in, one micro-rotation per clock.
// Define CORDIC_R_GAIN_COMP_EN to add a one-cycle COMP state that removes the CORDIC gain.
module cordic_r_iter #(
  parameter int unsigned SZ   = 16,
  parameter int unsigned ITER = 16
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [SZ-1:0] x_in,
  input  logic [SZ-1:0] y_in,
  input  logic [31:0]   angle_in,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [SZ:0]   x_out,
  output logic [SZ:0]   y_out
);

  localparam int unsigned W  = SZ + 2;
  localparam int unsigned IW = 5;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] DONE = 2'd2;
`ifdef CORDIC_R_GAIN_COMP_EN
  localparam logic [1:0] COMP = 2'd3;
`endif

  logic [1:0]          state_q, state_d;
  logic signed [W-1:0] x_q, y_q, x_d, y_d;
  logic signed [W-1:0] x_sh, y_sh;
  logic signed [W-1:0] xin_ext, yin_ext;
  logic [31:0]         z_q, z_d;
  logic [IW-1:0]       i_q, i_d;

  // atan(2^-i) in angle units where 2^32 = 360 degrees, rounded to nearest
  function automatic logic [31:0] atan_lut(input logic [IW-1:0] idx);
    logic [31:0] v;
    v = 32'd0;
    case (idx)
      5'd0:  v = 32'h2000_0000;
      5'd1:  v = 32'h12E4_051E;
      5'd2:  v = 32'h09FB_385B;
      5'd3:  v = 32'h0511_11D4;
      5'd4:  v = 32'h028B_0D43;
      5'd5:  v = 32'h0145_D7E1;
      5'd6:  v = 32'h00A2_F61E;
      5'd7:  v = 32'h0051_7C55;
      5'd8:  v = 32'h0028_BE53;
      5'd9:  v = 32'h0014_5F2F;
      5'd10: v = 32'h000A_2F98;
      5'd11: v = 32'h0005_17CC;
      5'd12: v = 32'h0002_8BE6;
      5'd13: v = 32'h0001_45F3;
      5'd14: v = 32'h0000_A2FA;
      5'd15: v = 32'h0000_517D;
      5'd16: v = 32'h0000_28BE;
      5'd17: v = 32'h0000_145F;
      5'd18: v = 32'h0000_0A30;
      5'd19: v = 32'h0000_0518;
      5'd20: v = 32'h0000_028C;
      5'd21: v = 32'h0000_0146;
      5'd22: v = 32'h0000_00A3;
      5'd23: v = 32'h0000_0051;
      5'd24: v = 32'h0000_0029;
      5'd25: v = 32'h0000_0014;
      5'd26: v = 32'h0000_000A;
      5'd27: v = 32'h0000_0005;
      5'd28: v = 32'h0000_0003;
      5'd29: v = 32'h0000_0001;
      5'd30: v = 32'h0000_0001;
      default: v = 32'd0;
    endcase
    return v;
  endfunction

  assign xin_ext = W'($signed(x_in));
  assign yin_ext = W'($signed(y_in));
  assign x_sh    = x_q >>> i_q;
  assign y_sh    = y_q >>> i_q;

`ifdef CORDIC_R_GAIN_COMP_EN
  // K ~= 0.60730 as shift-add, cancels the accumulated CORDIC gain
  function automatic logic signed [W-1:0] k_mul(input logic signed [W-1:0] v);
    return (v >>> 1) + (v >>> 3) - (v >>> 6) - (v >>> 9) - (v >>> 13);
  endfunction
`endif

  // next-state and datapath
  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    z_d     = z_q;
    i_d     = i_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          state_d = BUSY;
          i_d     = '0;
          case (angle_in[31:30])
            2'b01: begin
              x_d = -yin_ext;
              y_d = xin_ext;
              z_d = {2'b00, angle_in[29:0]};
            end
            2'b10: begin
              x_d = yin_ext;
              y_d = -xin_ext;
              z_d = {2'b11, angle_in[29:0]};
            end
            default: begin
              x_d = xin_ext;
              y_d = yin_ext;
              z_d = angle_in;
            end
          endcase
        end
      end
      BUSY: begin
        if (z_q[31]) begin
          x_d = x_q + y_sh;
          y_d = y_q - x_sh;
          z_d = z_q + atan_lut(i_q);
        end else begin
          x_d = x_q - y_sh;
          y_d = y_q + x_sh;
          z_d = z_q - atan_lut(i_q);
        end
        i_d = i_q + IW'(1);
        if (i_q == IW'(ITER - 1)) begin
`ifdef CORDIC_R_GAIN_COMP_EN
          state_d = COMP;
`else
          state_d = DONE;
`endif
        end
      end
`ifdef CORDIC_R_GAIN_COMP_EN
      COMP: begin
        x_d     = k_mul(x_q);
        y_d     = k_mul(y_q);
        state_d = DONE;
      end
`endif
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // state, datapath and handshake registers
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      x_q       <= '0;
      y_q       <= '0;
      z_q       <= '0;
      i_q       <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      state_q   <= state_d;
      x_q       <= x_d;
      y_q       <= y_d;
      z_q       <= z_d;
      i_q       <= i_d;
      in_ready  <= (state_d == IDLE);
      out_valid <= (state_d == DONE);
    end
  end

  assign x_out = x_q[SZ:0];
  assign y_out = y_q[SZ:0];

endmodule
